// File: rtl/pipeline_perf_counter_pkg.sv
// Shared encodings for the pipeline performance counters: FSM states and
// readback select codes.
package pipeline_perf_counter_pkg;

  typedef enum logic [1:0] {
    PERF_IDLE   = 2'd0,
    PERF_RUN    = 2'd1,
    PERF_FROZEN = 2'd2
  } perf_state_e;

  localparam logic [1:0] PERF_SEL_CYC   = 2'd0;
  localparam logic [1:0] PERF_SEL_STALL = 2'd1;
  localparam logic [1:0] PERF_SEL_FLUSH = 2'd2;
  localparam logic [1:0] PERF_SEL_RET   = 2'd3;

  localparam int PERF_NCNT = 4;

endpackage

// File: rtl/pipeline_perf_counter_sat_counter.sv
// One CNT_W event counter with a sticky overflow flag; holds or wraps at
// all-ones depending on SATURATE. clr wins over a same-edge increment.
module pipeline_perf_counter_sat_counter #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             flag
);

  logic at_max;
  assign at_max = &cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (en && inc) begin
      if (at_max) begin
        flag <= 1'b1;
        if (SATURATE == 0) cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pipeline_perf_counter.sv
// Cycle/stall/flush (and optional retire, `PERF_RETIRE_CNT_EN) counters with an
// IDLE/RUN/FROZEN gate FSM and a registered readback mux.
module pipeline_perf_counter
  import pipeline_perf_counter_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
`ifdef PERF_RETIRE_CNT_EN
  input  logic             retire_i,
`endif
  input  logic             freeze_i,
  input  logic             clear_i,
  input  logic [1:0]       rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [3:0]       sat_o,
  output logic [1:0]       state_o
);

  perf_state_e state, state_nxt;
  logic        run_en;
  logic [CNT_W-1:0] cnt_q [PERF_NCNT];
  logic [PERF_NCNT-1:0] flag_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= PERF_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PERF_IDLE:   if (start_i) state_nxt = PERF_RUN;
      PERF_RUN:    if (!start_i) state_nxt = PERF_IDLE;
                   else if (freeze_i) state_nxt = PERF_FROZEN;
      PERF_FROZEN: if (!start_i) state_nxt = PERF_IDLE;
                   else if (!freeze_i) state_nxt = PERF_RUN;
      default:     state_nxt = PERF_IDLE;
    endcase
  end

  // Count only on edges that stay in RUN, so the edge that freezes or stops
  // the pipeline view does not add a stray event.
  assign run_en = (state == PERF_RUN) && start_i && !freeze_i;

  pipeline_perf_counter_sat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cyc (
    .clk_i(clk_i), .rst_i(rst_i), .en(run_en), .inc(1'b1), .clr(clear_i),
    .cnt(cnt_q[PERF_SEL_CYC]), .flag(flag_q[PERF_SEL_CYC])
  );

  pipeline_perf_counter_sat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_stall (
    .clk_i(clk_i), .rst_i(rst_i), .en(run_en), .inc(stall_i & ~branch_i), .clr(clear_i),
    .cnt(cnt_q[PERF_SEL_STALL]), .flag(flag_q[PERF_SEL_STALL])
  );

  pipeline_perf_counter_sat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_flush (
    .clk_i(clk_i), .rst_i(rst_i), .en(run_en), .inc(flush_i), .clr(clear_i),
    .cnt(cnt_q[PERF_SEL_FLUSH]), .flag(flag_q[PERF_SEL_FLUSH])
  );

`ifdef PERF_RETIRE_CNT_EN
  pipeline_perf_counter_sat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_ret (
    .clk_i(clk_i), .rst_i(rst_i), .en(run_en), .inc(retire_i), .clr(clear_i),
    .cnt(cnt_q[PERF_SEL_RET]), .flag(flag_q[PERF_SEL_RET])
  );
`else
  assign cnt_q[PERF_SEL_RET]  = '0;
  assign flag_q[PERF_SEL_RET] = 1'b0;
`endif

  // Readback samples the pre-edge value of the selected counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rd_data_o <= '0;
    else        rd_data_o <= cnt_q[rd_sel_i];
  end

  assign sat_o   = flag_q;
  assign state_o = state;

endmodule

// File: tb/tb_pipeline_perf_counter.sv
// Randomized and directed bench for pipeline_perf_counter, run at CNT_W=8 with
// both SATURATE settings against an unbounded-count reference model.
module tb_pipeline_perf_counter;

  localparam int  W    = 8;
  localparam longint MAXV = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, stall, branch, flush, freeze, clear;
  logic [1:0] rd_sel;
`ifdef PERF_RETIRE_CNT_EN
  logic retire;
`endif
  logic [W-1:0] rd_s, rd_w;
  logic [3:0]   sat_s, sat_w;
  logic [1:0]   st_s, st_w;

  pipeline_perf_counter #(.CNT_W(W), .SATURATE(1)) dut_sat (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush),
`ifdef PERF_RETIRE_CNT_EN
    .retire_i(retire),
`endif
    .freeze_i(freeze), .clear_i(clear), .rd_sel_i(rd_sel),
    .rd_data_o(rd_s), .sat_o(sat_s), .state_o(st_s)
  );

  pipeline_perf_counter #(.CNT_W(W), .SATURATE(0)) dut_wrap (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush),
`ifdef PERF_RETIRE_CNT_EN
    .retire_i(retire),
`endif
    .freeze_i(freeze), .clear_i(clear), .rd_sel_i(rd_sel),
    .rd_data_o(rd_w), .sat_o(sat_w), .state_o(st_w)
  );

  // Reference: true event totals since last clear/reset; the DUT views are
  // derived as min(total, 255) and total mod 256, flagged once total > 255.
  longint raw [4];
  int     mst;          // 0 idle, 1 run, 2 frozen
  longint exp_rd_s, exp_rd_w;
  int     checks = 0;
  int     failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic longint view_sat(input longint v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic longint view_wrap(input longint v);
    return v % (MAXV + 1);
  endfunction

  function automatic logic [3:0] exp_flags();
    logic [3:0] f;
    for (int k = 0; k < 4; k++) f[k] = (raw[k] > MAXV);
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) raw[k] = 0;
    mst = 0; exp_rd_s = 0; exp_rd_w = 0;
  endtask

  task automatic model_edge();
    bit counting;
    if (!rst_n) return;
    exp_rd_s = view_sat(raw[rd_sel]);
    exp_rd_w = view_wrap(raw[rd_sel]);
    counting = (mst == 1) && start && !freeze;
    if (clear) begin
      for (int k = 0; k < 4; k++) raw[k] = 0;
    end else if (counting) begin
      raw[0] += 1;
      raw[1] += (stall && !branch) ? 1 : 0;
      raw[2] += flush ? 1 : 0;
`ifdef PERF_RETIRE_CNT_EN
      raw[3] += retire ? 1 : 0;
`endif
    end
    if (!start)                  mst = 0;
    else if (mst == 0)           mst = 1;
    else if (freeze)             mst = 2;
    else                         mst = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_rd_sat"},  rd_s,  exp_rd_s);
    chk({tag, "_rd_wrap"}, rd_w,  exp_rd_w);
    chk({tag, "_flg_sat"}, sat_s, exp_flags());
    chk({tag, "_flg_wrp"}, sat_w, exp_flags());
    chk({tag, "_st_sat"},  st_s,  mst);
    chk({tag, "_st_wrap"}, st_w,  mst);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic set_ev(input logic s, input logic b, input logic f);
    stall = s; branch = b; flush = f;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; freeze = 0; clear = 0; rd_sel = 0;
    set_ev(0, 0, 0);
`ifdef PERF_RETIRE_CNT_EN
    retire = 0;
`endif
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Plain counting, then readback of idle stall/flush counters
    start = 1;
    for (int i = 0; i < 12; i++) step("run");
    rd_sel = 1; step("rd_stall0");
    rd_sel = 2; step("rd_flush0");

    // Stalls under a branch are not counted
    rd_sel = 1;
    set_ev(1, 0, 0); repeat (3) step("stall");
    set_ev(1, 1, 0); repeat (2) step("stall_br");
    set_ev(0, 0, 0); step("stall_rd"); step("stall_rd2");

    // Simultaneous stall and flush
    set_ev(1, 0, 1); step("both");
    set_ev(0, 0, 0);
    for (int k = 0; k < 3; k++) begin rd_sel = 2'(k); step("both_rd"); end

    // Freeze with strobes active, then release
    set_ev(1, 0, 1); freeze = 1;
    for (int i = 0; i < 5; i++) begin rd_sel = 2'(i % 3); step("frz"); end
    chk("frz_state", st_s, 2);
    freeze = 0; step("unfrz"); step("unfrz2");
    set_ev(0, 0, 0);

    // Drive the cycle counter past all-ones from a cleared start
    clear = 1; step("clr");
    clear = 0; rd_sel = 0;
    for (int i = 0; i < 300; i++) step("sat");
    step("sat_rd");
    chk("sat300_rd_sat",  rd_s, 255);
    chk("sat300_rd_wrap", rd_w, 44);
    chk("sat300_flag_s",  sat_s[0], 1);
    chk("sat300_flag_w",  sat_w[0], 1);

    // Clear beats a same-edge flush increment
    rd_sel = 2; flush = 1; clear = 1; step("clr_fl");
    flush = 0; clear = 0; step("clr_fl_rd");
    chk("clr_flags", sat_s, 0);
    chk("clr_flush", rd_s, 0);

    // Async reset mid-RUN, observed without a clock edge
    set_ev(1, 0, 1); step("pre_rst");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_rd",   rd_s, 0);
    chk("arst_rdw",  rd_w, 0);
    chk("arst_sat",  sat_s, 0);
    chk("arst_state", st_s, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 39) != 0);
      freeze = ($urandom_range(0, 9) == 0);
      clear  = ($urandom_range(0, 599) == 0);
      stall  = $urandom_range(0, 1);
      branch = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 2) == 0);
`ifdef PERF_RETIRE_CNT_EN
      retire = $urandom_range(0, 1);
`endif
      rd_sel = 2'($urandom_range(0, 3));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
